// File: rtl/hilo_muldiv.sv
// HI/LO register pair with a multi-cycle multiply (fixed latency) and a radix-2 restoring divider.
// MTHI/MTLO take one edge; multiply/divide hold busy until completion, and flush abandons them.
module hilo_muldiv #(
  parameter int WIDTH   = 32,
  parameter int MUL_LAT = 3
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [2:0]       req_op,
  input  logic [WIDTH-1:0] req_a,
  input  logic [WIDTH-1:0] req_b,
  input  logic             flush,
  output logic             busy,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int CW = $clog2(WIDTH + MUL_LAT + 1);

  localparam logic [2:0] OP_MTHI  = 3'd0;
  localparam logic [2:0] OP_MTLO  = 3'd1;
  localparam logic [2:0] OP_MULT  = 3'd2;
  localparam logic [2:0] OP_MULTU = 3'd3;
  localparam logic [2:0] OP_DIV   = 3'd4;
  localparam logic [2:0] OP_DIVU  = 3'd5;

  typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV} state_t;

  state_t           state, state_nxt;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] op_a;     // raw rs; also the HI value for divide-by-zero
  logic [WIDTH-1:0] op_b;     // multiplier, or divisor magnitude while dividing
  logic [WIDTH-1:0] rem;
  logic [WIDTH-1:0] quo;      // dividend magnitude shifting out, quotient shifting in
  logic             mul_signed, q_neg, r_neg, div_zero;

  logic             accept, done;
  logic [2*WIDTH-1:0] ext_a, ext_b, prod;
  logic [WIDTH:0]   shifted, diff;
  logic             step_ok;
  logic [WIDTH-1:0] rem_step, quo_step, q_fix, r_fix;
  logic             a_neg, b_neg;

  assign busy      = (state != S_IDLE);
  assign req_ready = !busy;
  assign accept    = req_valid && req_ready && !flush;
  assign done      = busy && !flush && (cnt == '0);

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: begin
        if (accept && (req_op == OP_MULT || req_op == OP_MULTU)) state_nxt = S_MUL;
        if (accept && (req_op == OP_DIV  || req_op == OP_DIVU))  state_nxt = S_DIV;
      end
      S_MUL, S_DIV: begin
        if (flush || cnt == '0) state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // Full-width product: sign- or zero-extend to 2*WIDTH so the modular product is exact.
  always_comb begin
    ext_a = mul_signed ? {{WIDTH{op_a[WIDTH-1]}}, op_a} : {{WIDTH{1'b0}}, op_a};
    ext_b = mul_signed ? {{WIDTH{op_b[WIDTH-1]}}, op_b} : {{WIDTH{1'b0}}, op_b};
    prod  = ext_a * ext_b;
  end

  always_comb begin
    shifted  = {rem, quo[WIDTH-1]};
    diff     = shifted - {1'b0, op_b};
    step_ok  = !diff[WIDTH];
    rem_step = step_ok ? diff[WIDTH-1:0] : shifted[WIDTH-1:0];
    quo_step = {quo[WIDTH-2:0], step_ok};
    q_fix    = q_neg ? -quo_step : quo_step;
    r_fix    = r_neg ? -rem_step : rem_step;
    a_neg    = (req_op == OP_DIV) && req_a[WIDTH-1];
    b_neg    = (req_op == OP_DIV) && req_b[WIDTH-1];
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state      <= S_IDLE;
      cnt        <= '0;
      op_a       <= '0;
      op_b       <= '0;
      rem        <= '0;
      quo        <= '0;
      mul_signed <= 1'b0;
      q_neg      <= 1'b0;
      r_neg      <= 1'b0;
      div_zero   <= 1'b0;
      hi         <= '0;
      lo         <= '0;
    end else begin
      state <= state_nxt;
      if (accept) begin
        case (req_op)
          OP_MTHI: hi <= req_a;
          OP_MTLO: lo <= req_a;
          OP_MULT, OP_MULTU: begin
            op_a       <= req_a;
            op_b       <= req_b;
            mul_signed <= (req_op == OP_MULT);
            cnt        <= CW'(MUL_LAT - 1);
          end
          OP_DIV, OP_DIVU: begin
            op_a     <= req_a;
            op_b     <= b_neg ? -req_b : req_b;
            quo      <= a_neg ? -req_a : req_a;
            rem      <= '0;
            q_neg    <= a_neg ^ b_neg;
            r_neg    <= a_neg;
            div_zero <= (req_b == '0);
            cnt      <= CW'(WIDTH - 1);
          end
          default: ;
        endcase
      end
      if (state == S_MUL) begin
        cnt <= cnt - 1'b1;
        if (done) {hi, lo} <= prod;
      end
      if (state == S_DIV) begin
        cnt <= cnt - 1'b1;
        rem <= rem_step;
        quo <= quo_step;
        if (done) begin
          lo <= div_zero ? {WIDTH{1'b1}} : q_fix;
          hi <= div_zero ? op_a : r_fix;
        end
      end
    end
  end

endmodule
